ro_puf_response_engine: RTL
===========================

Name: ro_puf_response_engine

Overview:
- Challenge-driven response generator for the ring-oscillator PUF.
- Replaces fixed single-mux selection with an FSM that, for each response bit, enables a pair of oscillators and counts their rising edges over a fixed window.
- Compares the two counts and assembles a RESP_BITS-wide response.
- Sits between the Ring_Oscillator array (drives its enables, samples its outputs) and the PUF key/readout logic.

Parameters:
- SEL_W, 3, oscillator index width; NUM_RO = 2**SEL_W oscillators (index arithmetic wraps mod NUM_RO).
- CNT_W, 16, edge-counter width; counters saturate at 2**CNT_W-1.
- WINDOW, 1024, counting-window length in clk cycles (>=1).
- SETTLE_CYC, 4, cycles with enables on and counters held at 0 before counting (>=1).
- RESP_BITS, 8, response bits produced per challenge (>=1, <=256).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- chal_base  in  SEL_W  first oscillator index A0.
- chal_stride  in  SEL_W  pair offset; must be nonzero.
- ro_in  in  NUM_RO  raw Ring_Oscillator outputs (asynchronous to clk).
- ro_enable  out  NUM_RO  per-oscillator enable, one-hot-pair during measurement.
- busy  out  1  high from the cycle after an accepted start until resp_valid.
- resp_valid  out  1  one-cycle pulse; response/tie_mask valid and held until next accepted start.
- response  out  RESP_BITS  response[k] = 1 when count(A_k) > count(B_k).
- tie_mask  out  RESP_BITS  tie_mask[k] = 1 when counts are equal.
- err_stride  out  1  sticky; set on start with chal_stride==0, cleared on next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ro_enable, busy, resp_valid, response, tie_mask, err_stride, counters, and the bit index k all 0. Synchroniser flops cleared.
- Indices: A_k = (chal_base + k) mod NUM_RO; B_k = (A_k + chal_stride) mod NUM_RO. chal_base and chal_stride are latched at accept.
- Input path: each ro_in bit passes a 2-flop synchroniser plus a rising-edge detector (third flop). An edge increments the matching counter one cycle later. ro_in toggle rate must be below clk/2; faster rates alias and are outside the contract.
- FSM:
  - IDLE: on start with stride!=0, latch the challenge, clear response/tie_mask/err_stride, set k=0, go to SETTLE.
  - IDLE, start with stride==0: err_stride=1, stay in IDLE; no busy, no resp_valid.
  - SETTLE, SETTLE_CYC cycles: ro_enable has exactly bits A_k and B_k set; both counters held at 0.
  - COUNT, WINDOW cycles: counters increment on detected edges and saturate at max. Enables unchanged.
  - COMPARE, 1 cycle: write response[k] and tie_mask[k]; ro_enable=0. If k==RESP_BITS-1 go to DONE, else k++ and go to SETTLE.
  - DONE, 1 cycle: resp_valid=1, busy falls to 0 in the same cycle, then IDLE.
- Latency: resp_valid is asserted exactly RESP_BITS*(SETTLE_CYC+WINDOW+1)+1 cycles after the clk edge that samples an accepted start.
- Ties: equal counts, including both saturated, give response[k]=0 and tie_mask[k]=1.
- Boundary cases:
  - start while busy is ignored, with no effect on state or outputs.
  - start asserted in DONE is ignored.
  - start in the cycle after DONE is accepted.
  - Oscillators not in the current pair are never enabled.
  - Index wrap-around is mandatory: base=7, stride=1 gives pair (7,0) when SEL_W=3.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-sim for 2 cycles → all outputs 0 and ro_enable=8'h00 immediately; no resp_valid afterwards without a start.
- Ordered pairs: clk-based RO models where oscillator i toggles every i+2 clks; WINDOW=64, SETTLE_CYC=4, base=0, stride=1.
  - Expect response=8'h7F (bit7 is pair (7,0), so 0 is faster), tie_mask=8'h00.
  - resp_valid exactly 8*69+1=553 cycles after start.
  - ro_enable=8'h03 during bit 0 and 8'h81 during bit 7.
- Bad challenge: start with stride=0 → err_stride=1, busy stays 0, no resp_valid. A following start with stride=2 clears err_stride and runs normally.
- Ties/saturation: all models identical (toggle every 3 clks) → response=8'h00, tie_mask=8'hFF. With CNT_W=3, WINDOW=64 and unequal speeds, both counters saturate at 7 → every tie_mask bit=1.
- Reset mid-COUNT on bit 3: after release, state is IDLE with busy=0 and ro_enable=0. A new start with base=5, stride=3 completes with the correct response and the exact latency.
- Busy protection: pulse start again at cycle 100 with a different challenge → ignored; the result matches the first challenge and resp_valid pulses only once.

Source files
------------

// File: rtl/ro_puf_response_engine.sv
// Challenge-driven RO-PUF response engine: for each response bit, enables one oscillator
// pair, counts synchronised rising edges over a fixed window and compares the two counts.
module ro_puf_response_engine #(
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int RESP_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SEL_W-1:0]       chal_base,
  input  logic [SEL_W-1:0]       chal_stride,
  input  logic [2**SEL_W-1:0]    ro_in,
  output logic [2**SEL_W-1:0]    ro_enable,
  output logic                   busy,
  output logic                   resp_valid,
  output logic [RESP_BITS-1:0]   response,
  output logic [RESP_BITS-1:0]   tie_mask,
  output logic                   err_stride
);

  localparam int NUM_RO = 2**SEL_W;
  localparam int K_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int T_MAX  = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int T_W    = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [K_W-1:0]       k_reg, k_next;
  logic [T_W-1:0]       timer_reg, timer_next;
  logic [SEL_W-1:0]     a_idx_reg, a_idx_next;
  logic [SEL_W-1:0]     stride_reg, stride_next;
  logic [SEL_W-1:0]     b_idx, b_idx_next;
  logic [CNT_W-1:0]     cnt_a_reg, cnt_a_next;
  logic [CNT_W-1:0]     cnt_b_reg, cnt_b_next;
  logic                 busy_reg, busy_next;
  logic                 resp_valid_reg, resp_valid_next;
  logic                 err_stride_reg, err_stride_next;
  logic [RESP_BITS-1:0] response_reg, response_next;
  logic [RESP_BITS-1:0] tie_mask_reg, tie_mask_next;
  logic [NUM_RO-1:0]    sync1_reg, sync2_reg, sync3_reg;
  logic [NUM_RO-1:0]    edge_det, pair_mask, ro_enable_reg;

  // ro_in is asynchronous: two flops to resolve metastability, third for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= ro_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign edge_det   = sync2_reg & ~sync3_reg;
  assign b_idx      = a_idx_reg + stride_reg;
  assign b_idx_next = a_idx_next + stride_next;

  // Enable mask for the pair that will be active next cycle
  generate
    for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_pair
      assign pair_mask[gi] = (a_idx_next == SEL_W'(gi)) || (b_idx_next == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    timer_next      = timer_reg;
    a_idx_next      = a_idx_reg;
    stride_next     = stride_reg;
    cnt_a_next      = cnt_a_reg;
    cnt_b_next      = cnt_b_reg;
    busy_next       = busy_reg;
    resp_valid_next = 1'b0;
    err_stride_next = err_stride_reg;
    response_next   = response_reg;
    tie_mask_next   = tie_mask_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (chal_stride != '0) begin
            a_idx_next      = chal_base;
            stride_next     = chal_stride;
            response_next   = '0;
            tie_mask_next   = '0;
            err_stride_next = 1'b0;
            k_next          = '0;
            timer_next      = '0;
            busy_next       = 1'b1;
            state_next      = SETTLE;
          end else begin
            err_stride_next = 1'b1;
          end
        end
      end
      SETTLE: begin
        cnt_a_next = '0;
        cnt_b_next = '0;
        if (timer_reg == T_W'(SETTLE_CYC - 1)) begin
          timer_next = '0;
          state_next = COUNT;
        end else begin
          timer_next = timer_reg + T_W'(1);
        end
      end
      COUNT: begin
        if (edge_det[a_idx_reg] && (cnt_a_reg != CNT_MAX)) cnt_a_next = cnt_a_reg + CNT_W'(1);
        if (edge_det[b_idx] && (cnt_b_reg != CNT_MAX)) cnt_b_next = cnt_b_reg + CNT_W'(1);
        if (timer_reg == T_W'(WINDOW - 1)) begin
          timer_next = '0;
          state_next = COMPARE;
        end else begin
          timer_next = timer_reg + T_W'(1);
        end
      end
      COMPARE: begin
        response_next[k_reg] = (cnt_a_reg > cnt_b_reg);
        tie_mask_next[k_reg] = (cnt_a_reg == cnt_b_reg);
        if (k_reg == K_W'(RESP_BITS - 1)) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg + K_W'(1);
          a_idx_next = a_idx_reg + SEL_W'(1);
          state_next = SETTLE;
        end
      end
      DONE: begin
        resp_valid_next = 1'b1;
        busy_next       = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      timer_reg      <= '0;
      a_idx_reg      <= '0;
      stride_reg     <= '0;
      cnt_a_reg      <= '0;
      cnt_b_reg      <= '0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      err_stride_reg <= 1'b0;
      response_reg   <= '0;
      tie_mask_reg   <= '0;
      ro_enable_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      timer_reg      <= timer_next;
      a_idx_reg      <= a_idx_next;
      stride_reg     <= stride_next;
      cnt_a_reg      <= cnt_a_next;
      cnt_b_reg      <= cnt_b_next;
      busy_reg       <= busy_next;
      resp_valid_reg <= resp_valid_next;
      err_stride_reg <= err_stride_next;
      response_reg   <= response_next;
      tie_mask_reg   <= tie_mask_next;
      ro_enable_reg  <= ((state_next == SETTLE) || (state_next == COUNT)) ? pair_mask : '0;
    end
  end

  assign ro_enable  = ro_enable_reg;
  assign busy       = busy_reg;
  assign resp_valid = resp_valid_reg;
  assign response   = response_reg;
  assign tie_mask   = tie_mask_reg;
  assign err_stride = err_stride_reg;

endmodule
